serial_mag_compare: RTL and testbench

- Bit-serial N-bit unsigned magnitude comparator built around the team's 1-bit `comparator` cell, which outputs x = a>b, y = a==b and z = a<b.
- Accepts two WIDTH-bit operands over a valid/ready handshake and presents them to the cell one bit pair per clock, MSB first.
- Stops at the first differing bit and returns a one-hot gt/eq/lt result over a second valid/ready handshake.
- Sits between the operand source (switches/registers) and the display/LED stage.

---
 rtl/serial_mag_compare_pkg.sv | 20 ++
 rtl/comparator.sv | 22 ++
 rtl/serial_mag_compare.sv | 111 +++++++++++
 tb/tb_serial_mag_compare.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_compare_pkg.sv
// ---------------------------------------------------------------------------
// serial_mag_compare_pkg
//   Shared definitions for the bit-serial magnitude comparator.
//   - state_t : FSM state encoding (IDLE / SHIFT / DONE, code 3 unused)
//   - RES_*   : bit positions of gt/eq/lt inside the one-hot result vector
// ---------------------------------------------------------------------------
package serial_mag_compare_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int RES_GT = 0;
  localparam int RES_EQ = 1;
  localparam int RES_LT = 2;
  localparam int RES_W  = 3;

endpackage

// File: rtl/comparator.sv
// ---------------------------------------------------------------------------
// comparator
//   1-bit magnitude comparator cell.
//   Ports:
//     a, b : input bits
//     x    : a > b
//     y    : a == b
//     z    : a < b
// ---------------------------------------------------------------------------
module comparator (
  input  logic a,
  input  logic b,
  output logic x,
  output logic y,
  output logic z
);

  assign x = a & ~b;
  assign y = ~(a ^ b);
  assign z = ~a & b;

endmodule

// File: rtl/serial_mag_compare.sv
// ---------------------------------------------------------------------------
// serial_mag_compare
//   Bit-serial WIDTH-bit unsigned magnitude comparator. Operands are taken
//   over a valid/ready handshake, fed MSB first through the 1-bit comparator
//   cell, and the scan stops at the first differing bit. A one-hot gt/eq/lt
//   result plus the number of scan cycles is offered on a second handshake.
//   Ports:
//     clk, rst_n           : clock (rising edge), async active-low reset
//     in_valid / in_ready  : operand handshake (ready only in IDLE)
//     a, b                 : WIDTH-bit unsigned operands
//     out_valid / out_ready: result handshake (valid only in DONE)
//     gt, eq, lt           : one-hot comparison result
//     cmp_cycles           : SHIFT cycles used for this result (1..WIDTH)
//     busy                 : high while scanning
// ---------------------------------------------------------------------------
module serial_mag_compare
  import serial_mag_compare_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    cmp_cycles,
  output logic             busy
);

  state_t             state;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [CW-1:0]      cnt;
  logic [RES_W-1:0]   res;
  logic               bit_gt;
  logic               bit_eq;
  logic               bit_lt;

  comparator u_cell (
    .a (sa[WIDTH-1]),
    .b (sb[WIDTH-1]),
    .x (bit_gt),
    .y (bit_eq),
    .z (bit_lt)
  );

  // Handshake/status flags are pure decodes of the registered state.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_SHIFT);
  assign gt        = res[RES_GT];
  assign eq        = res[RES_EQ];
  assign lt        = res[RES_LT];

  // cnt counts remaining bit pairs after the current one; reaching zero with
  // equal bits means every pair matched. A shift of sa/sb (rather than an
  // index) keeps the cell always looking at the MSB position, and "<< 1"
  // stays legal when WIDTH is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sa         <= '0;
      sb         <= '0;
      cnt        <= '0;
      cmp_cycles <= '0;
      res        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sa         <= a;
            sb         <= b;
            cnt        <= CW'(WIDTH - 1);
            cmp_cycles <= '0;
            res        <= '0;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          cmp_cycles <= cmp_cycles + CW'(1);
          if (bit_gt) begin
            res[RES_GT] <= 1'b1;
            state       <= S_DONE;
          end else if (bit_lt) begin
            res[RES_LT] <= 1'b1;
            state       <= S_DONE;
          end else if (bit_eq && (cnt == '0)) begin
            res[RES_EQ] <= 1'b1;
            state       <= S_DONE;
          end else begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_compare
//   Self-checking bench for serial_mag_compare (WIDTH=8 and WIDTH=1 copies).
// ---------------------------------------------------------------------------
module tb_serial_mag_compare;

  typedef struct {
    logic gt;
    logic eq;
    logic lt;
    int   cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
    int         hold;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       gt, eq, lt, busy;
  logic [3:0] cmp_cycles;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic       gt1, eq1, lt1, busy1;
  logic [0:0] cmp_cycles1;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t sbq1[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  serial_mag_compare #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .eq(eq), .lt(lt), .cmp_cycles(cmp_cycles), .busy(busy)
  );

  serial_mag_compare #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .gt(gt1), .eq(eq1), .lt(lt1), .cmp_cycles(cmp_cycles1), .busy(busy1)
  );

  // Reference: scan from MSB, the first differing pair decides.
  function automatic exp_t model(input logic [7:0] va, input logic [7:0] vb);
    exp_t e;
    e.gt = 1'b0; e.eq = 1'b0; e.lt = 1'b0; e.cyc = 8;
    for (int i = 7; i >= 0; i--) begin
      if (va[i] != vb[i]) begin
        e.gt  = va[i];
        e.lt  = vb[i];
        e.cyc = 8 - i;
        return e;
      end
    end
    e.eq = 1'b1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected result and compare it with what DONE presents.
  task automatic compareResult();
    exp_t e;
    if (sbq.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
      return;
    end
    e = sbq.pop_front();
    checkOutput("gt", gt, e.gt);
    checkOutput("eq", eq, e.eq);
    checkOutput("lt", lt, e.lt);
    checkOutput("cmp_cycles", cmp_cycles, e.cyc);
    checkOutput("onehot", gt + eq + lt, 1);
  endtask

  task automatic waitDone(input int exp_cyc);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("latency", n, exp_cyc);
  endtask

  // One complete transaction on the WIDTH=8 instance, with `hold` cycles of
  // backpressure before the result is taken.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                               input exp_t e, input int hold);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    checkOutput("in_ready_idle", in_ready, 1);
    a = va; b = vb; in_valid = 1'b1;
    sbq.push_back(e);
    tick();
    in_valid = 1'b0;
    checkOutput("busy_after_accept", busy, 1);
    waitDone(e.cyc);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("hold_out_valid", out_valid, 1);
    end
    compareResult();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("out_valid_drop", out_valid, 0);
    checkOutput("in_ready_back", in_ready, 1);
  endtask

  task automatic run1(input logic va, input logic vb, input exp_t e);
    exp_t got;
    int n = 0;
    a1 = va; b1 = vb; in_valid1 = 1'b1;
    sbq1.push_back(e);
    tick();
    in_valid1 = 1'b0;
    while (!out_valid1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("w1_latency", n, 1);
    got = sbq1.pop_front();
    checkOutput("w1_gt", gt1, got.gt);
    checkOutput("w1_eq", eq1, got.eq);
    checkOutput("w1_lt", lt1, got.lt);
    checkOutput("w1_cmp_cycles", cmp_cycles1, got.cyc);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    checkOutput("w1_out_valid_drop", out_valid1, 0);
  endtask

  initial begin
    exp_t e;
    logic [7:0] ra, rb;

    vecs[0] = '{8'h80, 8'h7F, '{1'b1, 1'b0, 1'b0, 1}, 0};
    vecs[1] = '{8'hA4, 8'hA5, '{1'b0, 1'b0, 1'b1, 8}, 1};
    vecs[2] = '{8'h3C, 8'h3C, '{1'b0, 1'b1, 1'b0, 8}, 0};
    vecs[3] = '{8'h10, 8'h08, '{1'b1, 1'b0, 1'b0, 4}, 2};
    vecs[4] = '{8'h00, 8'hFF, '{1'b0, 1'b0, 1'b1, 1}, 0};
    vecs[5] = '{8'hFF, 8'hFF, '{1'b0, 1'b1, 1'b0, 8}, 0};
    vecs[6] = '{8'h5A, 8'h5E, '{1'b0, 1'b0, 1'b1, 6}, 0};

    // Reset held with in_valid asserted
    a = 8'h80; b = 8'h7F; in_valid = 1'b1; in_valid1 = 1'b1;
    repeat (3) tick();
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_result", {gt, eq, lt}, 0);
    checkOutput("rst_cmp_cycles", cmp_cycles, 0);
    checkOutput("rst_w1_state", {in_ready1, out_valid1, busy1}, 3'b100);
    in_valid = 1'b0; in_valid1 = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("post_rst_idle", {in_ready, busy, out_valid}, 3'b100);

    // Table-driven vectors
    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].hold);

    // Random vectors checked against the model
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 2 == 0) ? (ra ^ 8'($urandom_range(0, 15))) : 8'($urandom_range(0, 255));
      applyStimulus(ra, rb, model(ra, rb), i % 3);
    end

    // Backpressure with a pending in_valid that must wait for IDLE
    a = 8'h10; b = 8'h08; in_valid = 1'b1;
    sbq.push_back('{1'b1, 1'b0, 1'b0, 4});
    tick();
    in_valid = 1'b0;
    waitDone(4);
    a = 8'h55; b = 8'h55; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_gt", gt, 1);
      checkOutput("bp_cmp_cycles", cmp_cycles, 4);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_busy", busy, 0);
      tick();
    end
    compareResult();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp_release_idle", {in_ready, busy, out_valid}, 3'b100);
    sbq.push_back(model(8'h55, 8'h55));
    tick();
    in_valid = 1'b0;
    checkOutput("bp_accept_busy", busy, 1);
    checkOutput("bp_accept_cleared", {gt, eq, lt}, 0);
    checkOutput("bp_accept_cycles", cmp_cycles, 0);
    waitDone(8);
    compareResult();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of SHIFT
    a = 8'h01; b = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    checkOutput("mid_busy", busy, 1);
    checkOutput("mid_cycles", cmp_cycles, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_state", {in_ready, busy, out_valid}, 3'b100);
    checkOutput("mid_rst_result", {gt, eq, lt}, 0);
    checkOutput("mid_rst_cycles", cmp_cycles, 0);
    tick();
    rst_n = 1'b1;
    tick();
    e = '{1'b1, 1'b0, 1'b0, 8};
    applyStimulus(8'h01, 8'h00, e, 0);

    // WIDTH=1 instance
    run1(1'b1, 1'b0, '{1'b1, 1'b0, 1'b0, 1});
    run1(1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 1});
    run1(1'b1, 1'b1, '{1'b0, 1'b1, 1'b0, 1});
    run1(1'b0, 1'b0, '{1'b0, 1'b1, 1'b0, 1});

    checkOutput("scoreboard_drained", sbq.size() + sbq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
